hazard_stall_unit: RTL
======================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 Parameter MD_LATENCY, default 32: number of cycles a mul/div instruction occupies the execute slot; legal range 2..63.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset; asynchronous, active-low.
REQ-004 decValid  input  1  the decode-stage instruction is valid.
REQ-005 decReadA, decReadB  input  6 each  decode source ports; bit5=1 means no read, bits4:0 give the register.
REQ-006 decWrite  input  6  decode destination port; same encoding as the source ports.
REQ-007 decIsLoad  input  1  the decode instruction is lw.
REQ-008 decIsMultDiv  input  1  the decode instruction is mul or div.
REQ-009 stall  output  1  holds PC and the F/D register; a bubble enters X.
REQ-010 fwdA, fwdB  output  2 each  operand select for the instruction now in X: 00 register file, 01 X/M result, 10 M/W result.
REQ-011 exWrite, memWrite, wbWrite  output  6 each  tracked destination ports of the X, M and W slots.

Function
REQ-012 A port is a hazard candidate only if bit5=0 and bits4:0 != 0; a write to $0 never matches.
REQ-013 Each cycle without stall: the decode entry (decWrite, decIsLoad) moves to X if decValid, otherwise a bubble moves to X; X moves to M and M moves to W.
REQ-014 A bubble has write port 6'b100000 and load flag 0.
REQ-015 With stall=1, a bubble enters X in place of the decode entry; X->M->W still advances, except in the BUSY state.
REQ-016 Mul/div FSM has two states, IDLE and BUSY.
REQ-017 IDLE->BUSY when a mul/div entry is issued into X; a down-counter is loaded with MD_LATENCY-1.
REQ-018 In BUSY: the X entry is held, bubbles enter M, stall=1, and the counter decrements each cycle.
REQ-019 BUSY->IDLE on the cycle the counter equals 0; the X entry advances to M on that same edge.
REQ-020 stall is combinational from the current state and inputs; it is never asserted when decValid=0, except in BUSY.
REQ-021 fwdA and fwdB are registered at issue and align with the instruction in X; they are 00 while X holds a bubble.
REQ-022 Back-to-back mul/div: the second instruction stalls until the FSM returns to IDLE, then issues normally.

Reset
REQ-023 While resetn=0: X, M and W hold bubbles, the FSM is IDLE, the counter is 0, fwdA=fwdB=00, and stall=0.
REQ-024 Reset asserted during BUSY aborts the operation immediately; the first cycle after release behaves as IDLE with an empty pipeline.

Configuration
REQ-025 Macro HAZARD_FORWARD_EN is defined: stall is asserted only on load-use, i.e. X is a load and its write port matches a valid decode source.
REQ-026 With HAZARD_FORWARD_EN, a source match against non-load X gives select 01; otherwise a match against M gives 10; otherwise 00. The X match has priority over the M match.
REQ-027 Macro HAZARD_FORWARD_EN is undefined: stall is asserted on any valid source match against the X or M write port.
REQ-028 Without HAZARD_FORWARD_EN, fwdA and fwdB are constant 00.
REQ-029 W is never a stall source; the register file writes before it is read.

Structure
REQ-030 The shared package holds the 6-bit port type, the NO_PORT constant 6'b100000, and the fwd select encodings FWD_RF, FWD_XM and FWD_MW.
REQ-031 The mul/div FSM and its counter form sub-module multdiv_busy_ctr.
REQ-032 The slot registers and match logic stay in hazard_stall_unit.

Verification
REQ-033 add $3,$1,$2 then add $4,$3,$1, forwarding enabled -> stall=0; fwdA=01 on the second instruction in X.
REQ-034 lw $4,-3($2) then add $5,$4,$4 -> stall=1 for exactly 1 cycle; fwdA=fwdB=10 when the add reaches X.
REQ-035 Same sequence with HAZARD_FORWARD_EN undefined -> stall=1 for 2 cycles; fwd stays 00.
REQ-036 mul $3,$1,$2 with MD_LATENCY=4 -> stall=1 for 3 cycles; memWrite=$3 on the 4th edge after issue.
REQ-037 add $0,$1,$2 then add $5,$0,$0 -> no stall; fwd=00.
REQ-038 resetn pulled low for 1 cycle mid-BUSY -> next cycle: stall=0, exWrite=memWrite=wbWrite=6'b100000.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared port type, bubble constant, forward-select
// encodings, mul/div FSM states and the register-match helper.
package hazard_stall_unit_pkg;

    typedef logic [5:0] port_t;

    localparam port_t NO_PORT = 6'b100000;
    localparam int    CNT_W   = 6;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_XM = 2'b01,
        FWD_MW = 2'b10
    } fwd_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A source hits a destination only when it really reads a non-$0 register.
    function automatic logic port_hit(input port_t src, input port_t dst);
        return !src[5] && src[4:0] != 5'd0 && src == dst;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_multdiv_busy_ctr.sv
// multdiv_busy_ctr: mul/div occupancy FSM with its down-counter.
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   issue  : a mul/div entry enters the execute slot this edge
//   busy   : FSM is in BUSY
//   last   : final BUSY cycle (counter at 0); the execute entry leaves on this edge
module multdiv_busy_ctr
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic clock,
    input  logic resetn,
    input  logic issue,
    output logic busy,
    output logic last
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(MD_LATENCY - 1);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        state_next = state == MD_BUSY ? (cnt == '0 ? MD_IDLE : MD_BUSY)
                                      : (issue ? MD_BUSY : MD_IDLE);
        cnt_next   = state == MD_BUSY ? (cnt == '0 ? '0 : cnt - CNT_W'(1))
                                      : (issue ? LOAD : '0);
    end

    assign busy = state == MD_BUSY;
    assign last = busy && cnt == '0;

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: tracks X/M/W destination ports, raises stall on data
// hazards and mul/div occupancy, and produces operand forward selects.
//   clock, resetn            : clock, asynchronous active-low reset
//   decValid                 : decode instruction valid
//   decReadA, decReadB       : decode source ports (bit5=1 means no read)
//   decWrite                 : decode destination port
//   decIsLoad, decIsMultDiv  : decode instruction class
//   stall                    : hold PC and F/D, bubble into X
//   fwdA, fwdB               : operand selects for the instruction in X
//   exWrite, memWrite, wbWrite : tracked destination ports of X, M, W
// Build option: HAZARD_FORWARD_EN enables forwarding (stall only on load-use).
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_LATENCY = 32
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       decValid,
    input  logic [5:0] decReadA,
    input  logic [5:0] decReadB,
    input  logic [5:0] decWrite,
    input  logic       decIsLoad,
    input  logic       decIsMultDiv,
    output logic       stall,
    output logic [1:0] fwdA,
    output logic [1:0] fwdB,
    output logic [5:0] exWrite,
    output logic [5:0] memWrite,
    output logic [5:0] wbWrite
);

    port_t ex_w, mem_w, wb_w;
    logic  ex_load;
    logic  md_busy, md_last, hold, enter, issue, haz, md_stall;
    logic  hit_xa, hit_xb, hit_ma, hit_mb;

    multdiv_busy_ctr #(.MD_LATENCY(MD_LATENCY)) u_md (
        .clock  (clock),
        .resetn (resetn),
        .issue  (issue),
        .busy   (md_busy),
        .last   (md_last)
    );

    assign hit_xa = port_hit(decReadA, ex_w);
    assign hit_xb = port_hit(decReadB, ex_w);
    assign hit_ma = port_hit(decReadA, mem_w);
    assign hit_mb = port_hit(decReadB, mem_w);

    // X is frozen until the last BUSY cycle; in that cycle the mul/div moves
    // on, so only a following mul/div (or a real hazard) must wait.
    assign hold     = md_busy && !md_last;
    assign md_stall = md_busy && (!md_last || (decValid && decIsMultDiv));
    assign stall    = md_stall || (decValid && haz);
    assign enter    = decValid && !stall;
    assign issue    = enter && decIsMultDiv;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ex_w    <= NO_PORT;
            ex_load <= 1'b0;
            mem_w   <= NO_PORT;
            wb_w    <= NO_PORT;
        end else begin
            ex_w    <= hold ? ex_w : (enter ? decWrite : NO_PORT);
            ex_load <= hold ? ex_load : (enter && decIsLoad);
            mem_w   <= hold ? NO_PORT : ex_w;
            wb_w    <= mem_w;
        end
    end

`ifdef HAZARD_FORWARD_EN
    fwd_t fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

    assign haz = ex_load && (hit_xa || hit_xb);

    always_comb begin
        fwd_a_d = hit_xa ? FWD_XM : (hit_ma ? FWD_MW : FWD_RF);
        fwd_b_d = hit_xb ? FWD_XM : (hit_mb ? FWD_MW : FWD_RF);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (!hold) begin
            fwd_a_q <= enter ? fwd_a_d : FWD_RF;
            fwd_b_q <= enter ? fwd_b_d : FWD_RF;
        end
    end

    assign fwdA = fwd_a_q;
    assign fwdB = fwd_b_q;
`else
    logic load_unused;

    assign haz         = hit_xa || hit_xb || hit_ma || hit_mb;
    assign load_unused = ex_load;
    assign fwdA        = FWD_RF;
    assign fwdB        = FWD_RF;
`endif

    assign exWrite  = ex_w;
    assign memWrite = mem_w;
    assign wbWrite  = wb_w;

endmodule
